// File: rtl/btn_ce_debounce.sv
// rtl/btn_ce_debounce.sv - push-button synchroniser, debounce FSM and one-cycle ce pulse.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module btn_ce_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000,
  parameter int CNT_W = $clog2(
      (((DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY) > REPEAT_PERIOD)
        ? ((DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY) + 1
        : REPEAT_PERIOD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} state_t;

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_PERIOD - 1);
`endif

  state_t           state_q;
  logic             s1_q;
  logic             btn_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             pulse_q;
  logic             level_q;
`ifdef AUTO_REPEAT_EN
  logic             rep_q;
`endif

  assign cnt_inc_d = cnt_q + CNT_W'(1);
  assign pulse     = pulse_q;
  assign level     = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      btn_s_q <= s1_q;
    end
  end

  // The btn_s check always wins over the terminal count, so a bounce restarts the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      pulse_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            if (btn_s_q) state_q <= PRESS;
          end
          PRESS: begin
            if (!btn_s_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DB_TERM) begin
              state_q <= HELD;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          HELD: begin
            level_q <= 1'b1;
            if (!btn_s_q) begin
              state_q <= REL;
              cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
            end else if ((!rep_q && cnt_q == RD_TERM) || (rep_q && cnt_q == RP_TERM)) begin
              pulse_q <= 1'b1;
              cnt_q   <= '0;
              rep_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_inc_d;
`endif
            end
          end
          REL: begin
            if (btn_s_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
              rep_q   <= 1'b0;
`endif
            end else if (cnt_q == DB_TERM) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_ce_debounce.sv
// tb/tb_btn_ce_debounce.sv - scoreboard bench for btn_ce_debounce against a run-length model.
module tb_btn_ce_debounce;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic btn_in = 1'b0;
  logic pulse;
  logic level;

  always #5 clk = ~clk;

  btn_ce_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .btn_in(btn_in),
    .pulse(pulse),
    .level(level)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_q[$];
  int pulses_seen = 0;
  logic exp_level = 1'b0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int run = 0;
  int age = 0;
  bit held = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    exp_level = 1'b0;
    run = 0;
    age = 0;
    held = 1'b0;
    exp_q.delete();
  endfunction

  // Level flips once D+1 consecutive synchronised samples disagree with it.
  function automatic void model_edge(input logic b, input logic e);
    logic fin;
    cyc++;
    if (rst) begin
      model_clear();
      return;
    end
    fin  = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    if (!e) begin
      exp_level = 1'b0;
      run = 0;
      held = 1'b0;
    end else if (!exp_level) begin
      run = fin ? run + 1 : 0;
      if (run == D + 1) begin
        exp_level = 1'b1;
        run = 0;
        held = 1'b1;
        age = 0;
        exp_q.push_back(cyc);
      end
    end else if (!fin) begin
      held = 1'b0;
      run++;
      if (run == D + 1) begin
        exp_level = 1'b0;
        run = 0;
      end
    end else begin
      run = 0;
      if (!held) begin
        held = 1'b1;
        age = 0;
      end else begin
        age++;
      end
`ifdef AUTO_REPEAT_EN
      if (age == RD || (age > RD && (age - RD) % RP == 0)) exp_q.push_back(cyc);
`endif
    end
  endfunction

  task automatic tick(input logic b, input logic e);
    btn_in = b;
    en = e;
    @(posedge clk);
    model_edge(b, e);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_pulse", int'(pulse), 0);
    check("rst_level", int'(level), 0);
    tick(btn_in, en);
    #2;
    rst = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (pulse) begin
        pulses_seen++;
        if (exp_q.size() == 0) check("unexpected_pulse", cyc, -1);
        else check("pulse_cycle", cyc, exp_q.pop_front());
      end
      check("level", int'(level), int'(exp_level));
    end
  end

  initial begin : stim
    int base;
    int len;
    logic b;
    logic e;
    #1;
    check("reset_pulse", int'(pulse), 0);
    check("reset_level", int'(level), 0);
    repeat (3) tick(1'b0, 1'b1);
    #2;
    rst = 1'b0;

    repeat (20) tick(1'b1, 1'b1);
    repeat (12) tick(1'b0, 1'b1);

    tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b1);
    repeat (12) tick(1'b0, 1'b1);

    repeat (10) tick(1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b1);
    repeat (12) tick(1'b0, 1'b1);

    repeat (10) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    repeat (10) tick(1'b1, 1'b1);
    repeat (12) tick(1'b0, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() == 0; i++) tick(1'b1, 1'b1);
    check("pulse_before_rst", exp_q.size(), 1);
    async_reset();
    repeat (10) tick(1'b1, 1'b1);
    repeat (12) tick(1'b0, 1'b1);

    base = pulses_seen;
    repeat (10) begin
      repeat (8) tick(1'b1, 1'b1);
      repeat (8) tick(1'b0, 1'b1);
    end
    repeat (4) tick(1'b0, 1'b1);
    check("modulo4_y", (pulses_seen - base) % 4, 2);

    repeat (200) begin
      b = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 19) != 0);
      len = $urandom_range(1, 10);
      repeat (len) tick(b, e);
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    repeat (14) tick(1'b0, 1'b1);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
